four_in_demux: RTL and testbench

//  1-to-4 demultiplexer. Routes data input `in` to the one output lane chosen by `select`.
//  All other lanes are held at the idle value (0).

---
 rtl/four_in_demux_pkg.sv | 15 +
 rtl/four_in_demux_decode.sv | 25 ++
 rtl/four_in_demux.sv | 47 ++++
 tb/tb_four_in_demux.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/four_in_demux_pkg.sv
// Shared constants for the four-lane demultiplexer: lane count, select width,
// lane index values and the idle level driven on unselected lanes.
package four_in_demux_pkg;

  localparam int SEL_W     = 2;
  localparam int NUM_LANES = 4;

  localparam logic [SEL_W-1:0] LANE0 = 2'd0;
  localparam logic [SEL_W-1:0] LANE1 = 2'd1;
  localparam logic [SEL_W-1:0] LANE2 = 2'd2;
  localparam logic [SEL_W-1:0] LANE3 = 2'd3;

  localparam logic IDLE = 1'b0;

endpackage

// File: rtl/four_in_demux_decode.sv
// 2-to-4 one-hot lane decoder. Produces all-zero when disabled or when the
// select value is not a known lane index.
module four_in_demux_decode
  import four_in_demux_pkg::*;
(
  input  logic [SEL_W-1:0]     select,
  input  logic                 en,
  output logic [NUM_LANES-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      // An unknown select falls into default, so no lane ever picks up X.
      case (select)
        LANE0:   onehot = 4'b0001;
        LANE1:   onehot = 4'b0010;
        LANE2:   onehot = 4'b0100;
        LANE3:   onehot = 4'b1000;
        default: onehot = '0;
      endcase
    end
  end

endmodule

// File: rtl/four_in_demux.sv
// 1-to-4 demultiplexer: steers `in` onto the lane chosen by `select`, all other
// lanes idle. Output is either registered (1-cycle latency) or combinational.
module four_in_demux
  import four_in_demux_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter bit OUT_REG = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic [NUM_LANES*DATA_W-1:0] out,
  input  logic [SEL_W-1:0]            select,
  input  logic [DATA_W-1:0]           in,
  input  logic                        en
);

  logic [NUM_LANES-1:0]        onehot;
  logic [NUM_LANES*DATA_W-1:0] out_d;

  four_in_demux_decode u_decode (
    .select (select),
    .en     (en),
    .onehot (onehot)
  );

  always_comb begin
    out_d = {(NUM_LANES*DATA_W){IDLE}};
    for (int k = 0; k < NUM_LANES; k++) begin
      out_d[k*DATA_W +: DATA_W] = {DATA_W{onehot[k]}} & in;
    end
  end

  if (OUT_REG) begin : g_reg
    logic [NUM_LANES*DATA_W-1:0] out_q;

    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else     out_q <= out_d;
    end

    assign out = out_q;
  end else begin : g_comb
    // No state in this mode; reset simply gates the routed value.
    assign out = rst ? '0 : out_d;
  end

endmodule

// File: tb/tb_four_in_demux.sv
// Directed bench for four_in_demux: a registered 1-bit instance and a
// combinational 8-bit instance driven from one clock.
module tb_four_in_demux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_r, en_r, in_r;
  logic [1:0]  sel_r;
  logic [3:0]  out_r;

  logic        rst_c, en_c;
  logic [1:0]  sel_c;
  logic [7:0]  in_c;
  logic [31:0] out_c;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  four_in_demux #(.DATA_W(1), .OUT_REG(1'b1)) dut_r (
    .clk(clk), .rst(rst_r), .out(out_r), .select(sel_r), .in(in_r), .en(en_r)
  );

  four_in_demux #(.DATA_W(8), .OUT_REG(1'b0)) dut_c (
    .clk(clk), .rst(rst_c), .out(out_c), .select(sel_c), .in(in_c), .en(en_c)
  );

  // At most one lane non-idle, every cycle, on both instances.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] nz;
      for (int k = 0; k < 4; k++) nz[k] = |out_c[k*8 +: 8];
      checks = checks + 1;
      if (!$onehot0(out_r) || !$onehot0(nz)) begin
        errors = errors + 1;
        $display("FAIL onehot0: out_r=%b lanes_c=%b required at most one lane set", out_r, nz);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_r = 1'b1; en_r = 1'b1; in_r = 1'b1; sel_r = 2'd0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (out_r !== 4'b0000) begin
        errors++;
        $display("FAIL reset cycle %0d: out=%b required 0000", i, out_r);
      end
    end
    mon_en = 1'b1;
    rst_r = 1'b0;
  endtask

  task automatic test_lane0_toggle();
    logic [3:0] exp;
    sel_r = 2'd0; en_r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_r = i[0];
      cyc();
      exp = {3'b000, in_r};
      checks++;
      if (out_r !== exp) begin
        errors++;
        $display("FAIL lane0 toggle %0d: out=%b required %b", i, out_r, exp);
      end
    end
  endtask

  task automatic test_select_sweep();
    logic [3:0] exp;
    for (int s = 1; s < 4; s++) begin
      sel_r = s[1:0];
      for (int i = 0; i < 20; i++) begin
        in_r = ~i[0];
        cyc();
        exp = in_r ? (4'b0001 << s) : 4'b0000;
        checks++;
        if (out_r !== exp) begin
          errors++;
          $display("FAIL sweep sel=%0d step %0d: out=%b required %b", s, i, out_r, exp);
        end
      end
    end
  endtask

  task automatic test_enable();
    en_r = 1'b0; in_r = 1'b1; sel_r = 2'd2;
    cyc();
    checks++;
    if (out_r !== 4'b0000) begin
      errors++;
      $display("FAIL en low: out=%b required 0000", out_r);
    end
    en_r = 1'b1;
    cyc();
    checks++;
    if (out_r !== 4'b0100) begin
      errors++;
      $display("FAIL en raise: out=%b required 0100", out_r);
    end
  endtask

  task automatic test_reset_midstream();
    sel_r = 2'd3; in_r = 1'b1; en_r = 1'b1;
    cyc();
    checks++;
    if (out_r !== 4'b1000) begin
      errors++;
      $display("FAIL pre-reset stream: out=%b required 1000", out_r);
    end
    rst_r = 1'b1;
    cyc();
    checks++;
    if (out_r !== 4'b0000) begin
      errors++;
      $display("FAIL mid reset: out=%b required 0000", out_r);
    end
    rst_r = 1'b0;
    cyc();
    checks++;
    if (out_r !== 4'b1000) begin
      errors++;
      $display("FAIL post reset: out=%b required 1000", out_r);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    in_r = 1'b1; en_r = 1'b1;
    for (int s = 0; s < 4; s++) begin
      sel_r = s[1:0];
      cyc();
      checks++;
      if (out_r !== exp_tbl[s]) begin
        errors++;
        $display("FAIL back_to_back sel=%0d: out=%b required %b", s, out_r, exp_tbl[s]);
      end
    end
  endtask

  task automatic test_comb();
    logic [31:0] exp_tbl [5] = '{32'h0000A500, 32'h00000000, 32'hA5000000,
                                 32'h00000000, 32'h0000003C};
    rst_c = 1'b0; en_c = 1'b1; sel_c = 2'd1; in_c = 8'hA5;
    #1;
    checks++;
    if (out_c !== exp_tbl[0]) begin errors++; $display("FAIL comb sel1: out=%h required %h", out_c, exp_tbl[0]); end
    rst_c = 1'b1;
    #1;
    checks++;
    if (out_c !== exp_tbl[1]) begin errors++; $display("FAIL comb rst: out=%h required %h", out_c, exp_tbl[1]); end
    rst_c = 1'b0; sel_c = 2'd3;
    #1;
    checks++;
    if (out_c !== exp_tbl[2]) begin errors++; $display("FAIL comb sel3: out=%h required %h", out_c, exp_tbl[2]); end
    en_c = 1'b0;
    #1;
    checks++;
    if (out_c !== exp_tbl[3]) begin errors++; $display("FAIL comb en0: out=%h required %h", out_c, exp_tbl[3]); end
    en_c = 1'b1; sel_c = 2'd0; in_c = 8'h3C;
    #1;
    checks++;
    if (out_c !== exp_tbl[4]) begin errors++; $display("FAIL comb sel0: out=%h required %h", out_c, exp_tbl[4]); end
  endtask

  initial begin
    rst_c = 1'b1; en_c = 1'b0; sel_c = 2'd0; in_c = 8'h00;
    test_reset();
    test_lane0_toggle();
    test_select_sweep();
    test_enable();
    test_reset_midstream();
    test_back_to_back();
    test_comb();
    cyc();
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
